// File: rtl/pulse_sync_pkg.sv
// Shared definitions for the pulse synchronizer scheduler: FSM encoding,
// the minimum legal pulse spacing and a constant-evaluable clog2.
package pulse_sync_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam int MIN_GAP_FLOOR = 6;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/pulse_sync_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: searches from last_grant+1 (mod NUM_REQ)
// and returns a one-hot grant plus the winner's index.
module rr_arbiter
  import pulse_sync_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int ID_W = (clog2(NUM_REQ) < 1) ? 1 : clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx
);

  always_comb begin : search
    int   idx;
    logic found;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    // k runs 1..NUM_REQ so the previous winner is visited last
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_grant) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        found          = 1'b1;
        grant[idx]     = 1'b1;
        grant_idx      = idx[ID_W-1:0];
      end
    end
  end

endmodule

// File: rtl/pulse_sync_scheduler.sv
// Funnels events from NUM_REQ sources onto one pulse synchronizer input,
// spacing pulses MIN_GAP cycles apart and tagging each with its requester index.
module pulse_sync_scheduler
  import pulse_sync_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int CNT_WIDTH = 4,
  parameter int MIN_GAP   = 8,
  localparam int ID_W = (clog2(NUM_REQ) < 1) ? 1 : clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] event_in,
  input  logic               clear_ovfl,
  output logic               sync_pulse_out,
  output logic [ID_W-1:0]    sync_id_out,
  output logic               pending_any,
  output logic [NUM_REQ-1:0] ovfl_sticky
);

  localparam int GAP_W = clog2(MIN_GAP);

  if (MIN_GAP < MIN_GAP_FLOOR) begin : g_gap_check
    $error("pulse_sync_scheduler: MIN_GAP below the synchronizer floor");
  end
  if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_req_check
    $error("pulse_sync_scheduler: NUM_REQ must be 2..16");
  end

  state_t               state;
  logic [GAP_W-1:0]     gap_cnt;
  logic [ID_W-1:0]      last_grant;
  logic [CNT_WIDTH-1:0] cnt [NUM_REQ];

  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ-1:0]   arb_grant;
  logic [ID_W-1:0]      arb_idx;
  logic                 grant_en;
  logic                 do_grant;
  logic [NUM_REQ-1:0]   grant;
  logic [NUM_REQ-1:0]   ovfl_set;

  always_comb begin
    req      = '0;
    ovfl_set = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req[i] = (cnt[i] != '0);
    end
    // The last GAP cycle doubles as IDLE so spacing is exactly MIN_GAP
    grant_en = (state == ST_IDLE) || (state == ST_GAP && gap_cnt == '0);
    do_grant = grant_en && (|req);
    grant    = grant_en ? arb_grant : '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      ovfl_set[i] = event_in[i] && !grant[i] && (cnt[i] == '1);
    end
  end

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req        (req),
    .last_grant (last_grant),
    .grant      (arb_grant),
    .grant_idx  (arb_idx)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REQ; i++) cnt[i] <= '0;
      ovfl_sticky <= '0;
      pending_any <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (event_in[i] && !grant[i] && cnt[i] != '1) cnt[i] <= cnt[i] + 1'b1;
        else if (!event_in[i] && grant[i])           cnt[i] <= cnt[i] - 1'b1;
      end
      ovfl_sticky <= ovfl_set | (clear_ovfl ? '0 : ovfl_sticky);
      pending_any <= |req;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= ST_IDLE;
      gap_cnt        <= '0;
      last_grant     <= ID_W'(NUM_REQ - 1);
      sync_pulse_out <= 1'b0;
      sync_id_out    <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_GAP: begin
          if (state == ST_GAP && gap_cnt != '0) begin
            gap_cnt <= gap_cnt - 1'b1;
          end else if (do_grant) begin
            state          <= ST_PULSE;
            sync_pulse_out <= 1'b1;
            sync_id_out    <= arb_idx;
            last_grant     <= arb_idx;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_PULSE: begin
          sync_pulse_out <= 1'b0;
          gap_cnt        <= GAP_W'(MIN_GAP - 2);
          state          <= ST_GAP;
        end
        default: begin
          sync_pulse_out <= 1'b0;
          state          <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_sync_scheduler.sv
// Directed bench for pulse_sync_scheduler with hand-computed pulse times and ids.
module tb_pulse_sync_scheduler;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] event_in;
  logic       clear_ovfl;
  logic       sync_pulse_out;
  logic [1:0] sync_id_out;
  logic       pending_any;
  logic [3:0] ovfl_sticky;

  int cyc = 0;
  int t0 = 0;
  int errors = 0;
  int checks = 0;
  int p_time[$];
  int p_id[$];

  always #5 clk = ~clk;

  pulse_sync_scheduler #(.NUM_REQ(4), .CNT_WIDTH(4), .MIN_GAP(8)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .event_in       (event_in),
    .clear_ovfl     (clear_ovfl),
    .sync_pulse_out (sync_pulse_out),
    .sync_id_out    (sync_id_out),
    .pending_any    (pending_any),
    .ovfl_sticky    (ovfl_sticky)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one cycle, sample #1 after the edge, log any pulse relative to t0
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (sync_pulse_out === 1'b1) begin
      p_time.push_back(cyc - t0);
      p_id.push_back(int'(sync_id_out));
    end
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    event_in   = '0;
    clear_ovfl = 1'b0;
    reset_n    = 1'b0;
    run(2);
    reset_n = 1'b1;
    tick();
  endtask

  task automatic begin_test();
    p_time.delete();
    p_id.delete();
    t0 = cyc;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    event_in   = '0;
    clear_ovfl = 1'b0;
    reset_n    = 1'b0;
    #3;
    chk("rst pulse", sync_pulse_out, 0);
    chk("rst id", sync_id_out, 0);
    chk("rst pending", pending_any, 0);
    chk("rst ovfl", ovfl_sticky, 0);
    run(2);
    reset_n = 1'b1;
    tick();

    // 1: single event on req 2 -> pulse exactly at t+2
    begin_test();
    event_in = 4'b0100;
    tick();
    event_in = '0;
    chk("t1 pulse@1", sync_pulse_out, 0);
    tick();
    chk("t1 pulse@2", sync_pulse_out, 1);
    chk("t1 id", sync_id_out, 2);
    chk("t1 pending@2", pending_any, 1);
    tick();
    chk("t1 pulse@3", sync_pulse_out, 0);
    chk("t1 pending@3", pending_any, 0);
    run(20);
    chk("t1 npulses", p_time.size(), 1);

    // 2: all four at once -> ids 0..3 spaced by MIN_GAP
    do_reset();
    begin_test();
    event_in = 4'b1111;
    tick();
    event_in = '0;
    run(45);
    chk("t2 npulses", p_time.size(), 4);
    if (p_time.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("t2 time%0d", i), p_time[i], 2 + 8 * i);
        chk($sformatf("t2 id%0d", i), p_id[i], i);
      end
    end

    // 3: req 1 held 20 cycles. Grants fall on t+1, t+9, t+17 alongside events;
    // counter reaches 15 after t+16, so events at t+18, t+19 are lost: 18 pulses.
    do_reset();
    begin_test();
    event_in = 4'b0010;
    run(20);
    event_in = '0;
    chk("t3 ovfl", ovfl_sticky, 4'b0010);
    run(160);
    chk("t3 npulses", p_time.size(), 18);
    if (p_time.size() == 18) chk("t3 last time", p_time[17], 2 + 17 * 8);
    bad = 0;
    foreach (p_id[i]) if (p_id[i] != 1) bad++;
    chk("t3 ids", bad, 0);
    chk("t3 pending end", pending_any, 0);

    // 4: overflow set beats clear in the same cycle; clear alone then wins
    do_reset();
    event_in = 4'b0001;
    run(18);
    chk("t4 ovfl pre", ovfl_sticky, 0);
    tick();
    chk("t4 ovfl set", ovfl_sticky, 4'b0001);
    clear_ovfl = 1'b1;
    tick();
    chk("t4 ovfl set+clr", ovfl_sticky, 4'b0001);
    event_in = '0;
    tick();
    chk("t4 ovfl clr", ovfl_sticky, 0);
    clear_ovfl = 1'b0;

    // 5: event coincides with grant on req 3 -> count held, second pulse follows
    do_reset();
    begin_test();
    event_in = 4'b1000;
    run(2);
    event_in = '0;
    run(30);
    chk("t5 npulses", p_time.size(), 2);
    if (p_time.size() == 2) begin
      chk("t5 time1", p_time[1], 10);
      chk("t5 id0", p_id[0], 3);
      chk("t5 id1", p_id[1], 3);
    end

    // 6: async reset mid-GAP with work pending
    do_reset();
    begin_test();
    event_in = 4'b1111;
    tick();
    event_in = '0;
    run(11);
    chk("t6 id pre", sync_id_out, 1);
    chk("t6 pending pre", pending_any, 1);
    reset_n = 1'b0;
    #1;
    chk("t6 pulse rst", sync_pulse_out, 0);
    chk("t6 id rst", sync_id_out, 0);
    chk("t6 pending rst", pending_any, 0);
    run(2);
    reset_n = 1'b1;
    begin_test();
    run(30);
    chk("t6 no pulse", p_time.size(), 0);
    begin_test();
    event_in = 4'b0110;
    tick();
    event_in = '0;
    run(5);
    chk("t6 new npulses", p_time.size(), 1);
    if (p_time.size() == 1) begin
      chk("t6 new time", p_time[0], 2);
      chk("t6 new id", p_id[0], 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
